// File: rtl/peripheral_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding peripheral master.
// Issues the winner's command as one-cycle pulses, then holds the command until completion.
module peripheral_arbiter (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        P0_REQ_VALID,
   input  logic [63:0] P0_REQ_ADDR,
   input  logic [63:0] P0_REQ_WDATA,
   input  logic [7:0]  P0_REQ_WSTRB,
   input  logic        P0_REQ_WRITE,
   input  logic        P0_REQ_WORD,
   output logic        P0_REQ_READY,
   output logic        P0_RESP_VALID,
   output logic [63:0] P0_RESP_RDATA,
   input  logic        P1_REQ_VALID,
   input  logic [63:0] P1_REQ_ADDR,
   input  logic [63:0] P1_REQ_WDATA,
   input  logic [7:0]  P1_REQ_WSTRB,
   input  logic        P1_REQ_WRITE,
   input  logic        P1_REQ_WORD,
   output logic        P1_REQ_READY,
   output logic        P1_RESP_VALID,
   output logic [63:0] P1_RESP_RDATA,
   output logic        ADDR_TO_PERI_VALID,
   output logic [63:0] ADDR_TO_PERI,
   output logic [63:0] DATA_TO_PERI,
   output logic [7:0]  WSTRB,
   output logic        WRITE_TO_PERI,
   output logic        PERI_WORD_ACCESS,
   input  logic        DATA_FROM_PERI_READY,
   input  logic [63:0] DATA_FROM_PERI,
   output logic        BUSY,
   output logic        GRANT_ID
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        grant_q, grant_d;
   logic        addr_vld_q, addr_vld_d;
   logic        rdy0_q, rdy0_d, rdy1_q, rdy1_d;
   logic        rsp0_q, rsp0_d, rsp1_q, rsp1_d;
   logic [63:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        write_q, write_d, word_q, word_d;

   logic        winner, issue, done;

   // On a tie the port that did not complete last wins; a lone requester always wins.
   assign winner = (P0_REQ_VALID && P1_REQ_VALID) ? ~last_q : P1_REQ_VALID;
   assign issue  = (state_q == IDLE) && (P0_REQ_VALID || P1_REQ_VALID);
   assign done   = (state_q == WAIT) && DATA_FROM_PERI_READY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (issue)     state_d = WAIT;
      else if (done) state_d = IDLE;
   end

   always_comb begin
      last_d     = last_q;
      grant_d    = grant_q;
      addr_vld_d = 1'b0;
      rdy0_d     = 1'b0;
      rdy1_d     = 1'b0;
      rsp0_d     = 1'b0;
      rsp1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      write_d    = write_q;
      word_d     = word_q;
      if (issue) begin
         grant_d    = winner;
         addr_vld_d = 1'b1;
         rdy0_d     = ~winner;
         rdy1_d     = winner;
         addr_d     = winner ? P1_REQ_ADDR  : P0_REQ_ADDR;
         wdata_d    = winner ? P1_REQ_WDATA : P0_REQ_WDATA;
         wstrb_d    = winner ? P1_REQ_WSTRB : P0_REQ_WSTRB;
         write_d    = winner ? P1_REQ_WRITE : P0_REQ_WRITE;
         word_d     = winner ? P1_REQ_WORD  : P0_REQ_WORD;
      end
      // Round-robin history advances on completion, not on issue.
      if (done) begin
         last_d = grant_q;
         if (grant_q) begin
            rsp1_d   = 1'b1;
            rdata1_d = DATA_FROM_PERI;
         end else begin
            rsp0_d   = 1'b1;
            rdata0_d = DATA_FROM_PERI;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         last_q     <= 1'b1;
         grant_q    <= 1'b0;
         addr_vld_q <= 1'b0;
         rdy0_q     <= 1'b0;
         rdy1_q     <= 1'b0;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         write_q    <= 1'b0;
         word_q     <= 1'b0;
      end else begin
         last_q     <= last_d;
         grant_q    <= grant_d;
         addr_vld_q <= addr_vld_d;
         rdy0_q     <= rdy0_d;
         rdy1_q     <= rdy1_d;
         rsp0_q     <= rsp0_d;
         rsp1_q     <= rsp1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         write_q    <= write_d;
         word_q     <= word_d;
      end
   end

   assign P0_REQ_READY       = rdy0_q;
   assign P1_REQ_READY       = rdy1_q;
   assign P0_RESP_VALID      = rsp0_q;
   assign P1_RESP_VALID      = rsp1_q;
   assign P0_RESP_RDATA      = rdata0_q;
   assign P1_RESP_RDATA      = rdata1_q;
   assign ADDR_TO_PERI_VALID = addr_vld_q;
   assign ADDR_TO_PERI       = addr_q;
   assign DATA_TO_PERI       = wdata_q;
   assign WSTRB              = wstrb_q;
   assign WRITE_TO_PERI      = write_q;
   assign PERI_WORD_ACCESS   = word_q;
   assign BUSY               = (state_q == WAIT);
   assign GRANT_ID           = grant_q;

endmodule
